fifo_level: RTL and testbench

- Parametrised successor to the basic circular-queue FIFO.
- Adds an occupancy count, almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) or registered read mode, synchronous flush, and sticky overflow/underflow error flags.
- Single clock domain; buffers byte/word streams between producers and consumers such as UART, SPI and display pipelines.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_level_ctrl.sv | 103 ++++++++++
 rtl/fifo_level.sv | 87 ++++++++
 tb/tb_fifo_level.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO family: count width helper and error-flag bit positions.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_level_ctrl.sv
// FIFO control path: pointers, occupancy count, accept logic, level flags and sticky errors.
module fifo_level_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr,
  input  logic                               rd,
  input  logic                               flush,
  input  logic                               clr_err,
  output logic                               wr_acc,
  output logic                               rd_acc,
  output logic [ADDR_WIDTH-1:0]              w_ptr,
  output logic [ADDR_WIDTH-1:0]              r_ptr,
  output logic [count_width(ADDR_WIDTH)-1:0] count,
  output logic                               empty,
  output logic                               full,
  output logic                               almost_empty,
  output logic                               almost_full,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  ae_q, ae_d, af_q, af_d;
  logic [ERR_W-1:0]      err_q, err_d, err_set;

  // i_wr/i_rd are requests; a word moves only in a cycle where its accept is high.
  // A rejected request leaves pointers, count and data untouched; only the sticky
  // error flags record it. Flush overrides both requests and raises no error.
  always_comb begin
    wr_acc  = ~flush & wr & (~full_q | rd);
    rd_acc  = ~flush & rd & ~empty_q;
    w_ptr_d = w_ptr_q + ADDR_WIDTH'(wr_acc);
    r_ptr_d = r_ptr_q + ADDR_WIDTH'(rd_acc);
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end

    err_set          = '0;
    err_set[ERR_OVF] = ~flush & wr & full_q & ~rd;
    err_set[ERR_UDF] = ~flush & rd & empty_q;
    err_d            = (err_q & ~{ERR_W{clr_err}}) | err_set;

    // Flags follow the next count so they move on the same edge as o_count.
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      err_q   <= err_d;
    end
  end

  assign w_ptr        = w_ptr_q;
  assign r_ptr        = r_ptr_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = err_q[ERR_OVF];
  assign underflow    = err_q[ERR_UDF];

endmodule

// File: rtl/fifo_level.sv
// Level-reporting FIFO: storage array plus FWFT or registered read path around fifo_level_ctrl.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b1,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_wr,
  input  logic [DATA_WIDTH-1:0]              i_w_data,
  input  logic                               i_rd,
  input  logic                               i_flush,
  input  logic                               i_clr_err,
  output logic [DATA_WIDTH-1:0]              o_r_data,
  output logic                               o_empty,
  output logic                               o_full,
  output logic                               o_almost_empty,
  output logic                               o_almost_full,
  output logic [count_width(ADDR_WIDTH)-1:0] o_count,
  output logic                               o_overflow,
  output logic                               o_underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_level: AF_LEVEL must not exceed the FIFO depth");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_level: AE_LEVEL must be below the FIFO depth");
  end

  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  fifo_level_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_ctrl (
    .clk          (i_clk),
    .rst          (i_reset),
    .wr           (i_wr),
    .rd           (i_rd),
    .flush        (i_flush),
    .clr_err      (i_clr_err),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr),
    .count        (o_count),
    .empty        (o_empty),
    .full         (o_full),
    .almost_empty (o_almost_empty),
    .almost_full  (o_almost_full),
    .overflow     (o_overflow),
    .underflow    (o_underflow)
  );

  // Storage is deliberately left unreset so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[w_ptr] <= i_w_data;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem_q[r_ptr];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  if (FWFT) begin : g_fwft
    assign o_r_data = mem_q[r_ptr];
  end else begin : g_reg
    assign o_r_data = rdata_q;
  end

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: one FWFT and one registered-read instance share stimulus and a queue model.
module tb_fifo_level;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_wr = 1'b0, i_rd = 1'b0, i_flush = 1'b0, i_clr = 1'b0;
  logic [DW-1:0] i_data = '0;

  logic [DW-1:0] rd_f, rd_r;
  logic          emp_f, ful_f, ae_f, af_f, ovf_f, udf_f;
  logic          emp_r, ful_r, ae_r, af_r, ovf_r, udf_r;
  logic [AW:0]   cnt_f, cnt_r;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_ovf = 1'b0, m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_level #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) dut_f (
    .i_clk(clk), .i_reset(rst), .i_wr(i_wr), .i_w_data(i_data), .i_rd(i_rd),
    .i_flush(i_flush), .i_clr_err(i_clr), .o_r_data(rd_f), .o_empty(emp_f),
    .o_full(ful_f), .o_almost_empty(ae_f), .o_almost_full(af_f), .o_count(cnt_f),
    .o_overflow(ovf_f), .o_underflow(udf_f)
  );

  fifo_level #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) dut_r (
    .i_clk(clk), .i_reset(rst), .i_wr(i_wr), .i_w_data(i_data), .i_rd(i_rd),
    .i_flush(i_flush), .i_clr_err(i_clr), .o_r_data(rd_r), .o_empty(emp_r),
    .o_full(ful_r), .o_almost_empty(ae_r), .o_almost_full(af_r), .o_count(cnt_r),
    .o_overflow(ovf_r), .o_underflow(udf_r)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      int n;
      logic ovf_set, udf_set;
      n = exp_q.size();
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (i_flush) begin
        exp_q.delete();
      end else begin
        ovf_set = i_wr && (n == DEPTH) && !i_rd;
        udf_set = i_rd && (n == 0);
        if (i_rd && n > 0) m_rdata = exp_q.pop_front();
        if (i_wr && (n < DEPTH || i_rd)) exp_q.push_back(i_data);
      end
      if (i_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (ovf_set) m_ovf = 1'b1;
      if (udf_set) m_udf = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag, input logic [AW:0] cnt, input logic e,
                             input logic f, input logic ae, input logic af,
                             input logic ov, input logic ud);
    int n;
    n = exp_q.size();
    check({tag, "_count"}, 32'(cnt), 32'(n));
    check({tag, "_empty"}, 32'(e), 32'(n == 0));
    check({tag, "_full"}, 32'(f), 32'(n == DEPTH));
    check({tag, "_aempty"}, 32'(ae), 32'(n <= AE));
    check({tag, "_afull"}, 32'(af), 32'(n >= AF));
    check({tag, "_ovf"}, 32'(ov), 32'(m_ovf));
    check({tag, "_udf"}, 32'(ud), 32'(m_udf));
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check_flags("fwft", cnt_f, emp_f, ful_f, ae_f, af_f, ovf_f, udf_f);
    check_flags("reg", cnt_r, emp_r, ful_r, ae_r, af_r, ovf_r, udf_r);
    if (exp_q.size() > 0) check("fwft_head", 32'(rd_f), 32'(exp_q[0]));
    check("reg_rdata", 32'(rd_r), 32'(m_rdata));
  end

  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                      input logic fl, input logic clr);
    i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr = clr;
    @(posedge clk);
    @(negedge clk);
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_empty", 32'(emp_f), 32'd1);
    check("rst_aempty", 32'(ae_r), 32'd1);
    check("rst_count", 32'(cnt_f), 32'd0);
    check("rst_rdata_reg", 32'(rd_r), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("idle_empty", 32'(emp_r), 32'd1);
    check("idle_errs", 32'({ovf_f, udf_f}), 32'd0);

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 1)  check("fwft_first_word", 32'(rd_f), 32'h01);
      if (i == 13) check("af_at13", 32'(af_f), 32'd0);
      if (i == 14) check("af_at14", 32'(af_f), 32'd1);
    end
    check("full_at16", 32'(ful_f), 32'd1);
    check("count16", 32'(cnt_r), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (i == 1) begin
        check("reg_after_rd1", 32'(rd_r), 32'h01);
        check("fwft_after_rd1", 32'(rd_f), 32'h02);
      end
    end
    check("drain_empty", 32'(emp_f), 32'd1);
    check("drain_last_reg", 32'(rd_r), 32'h10);

    // Full with simultaneous read and write.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
    check("rw_full_count", 32'(cnt_f), 32'd16);
    check("rw_full_noovf", 32'(ovf_r), 32'd0);
    check("rw_full_reg", 32'(rd_r), 32'h05);
    check("rw_full_head", 32'(rd_f), 32'h06);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("rw_last_reg", 32'(rd_r), 32'hA4);

    // Empty with simultaneous read and write.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("rw_empty_count", 32'(cnt_r), 32'd1);
    check("rw_empty_udf", 32'(udf_f), 32'd1);
    check("rw_empty_reg_hold", 32'(rd_r), 32'hA4);
    check("rw_empty_head", 32'(rd_f), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("rd_55", 32'(rd_r), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("udf_cleared", 32'(udf_r), 32'd0);

    // Overflow and clear priority.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_f), 32'd1);
    check("ovf_count", 32'(cnt_f), 32'd16);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    check("ovf_set_beats_clr", 32'(ovf_r), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(ovf_f), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("ovf_last_reg", 32'(rd_r), 32'h2F);

    // Past the pointer wrap, then flush.
    for (int i = 0; i < 12; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    check("flush_count", 32'(cnt_f), 32'd0);
    check("flush_empty", 32'(emp_r), 32'd1);
    check("flush_keeps_rdata", 32'(rd_r), 32'h2F);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    check("flush_no_udf", 32'(udf_f), 32'd0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", 32'(rd_f), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("post_flush_reg", 32'(rd_r), 32'h33);

    // Async reset mid-burst.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("burst_count7", 32'(cnt_f), 32'd7);
    check("burst_udf", 32'(udf_r), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(cnt_f), 32'd0);
    check("arst_empty", 32'(emp_r), 32'd1);
    check("arst_aempty", 32'(ae_f), 32'd1);
    check("arst_udf", 32'(udf_r), 32'd0);
    check("arst_rdata", 32'(rd_r), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("resume_count", 32'(cnt_r), 32'd1);
    check("resume_head", 32'(rd_f), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("resume_reg", 32'(rd_r), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
